mod_mul_pipe: RTL
=================

Name: mod_mul_pipe

Overview:
- Next-generation modular multiplier for the CRYSTALS NTT datapath.
- Computes a*b modulo Q over LANES parallel lanes, with a per-transaction mode: Montgomery result (a*b*R^-1 mod Q) or plain result (a*b mod Q).
- Fixed-latency pipeline with valid/ready handshake, stall support and tag passthrough; output always canonical in [0, Q-1].
- Feeds butterfly units and pointwise multiply; replaces the fixed Montgomery/KRED multiplier.

Parameters:
- LANES, 2, number of independent multiplier lanes sharing one handshake
- DATA_WIDTH, 12, operand/result width; R = 2^DATA_WIDTH
- Q, 3329, modulus; must be odd and satisfy Q < 2^DATA_WIDTH
- TAG_WIDTH, 4, width of sideband tag carried alongside data

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat this cycle
- in_mode  in  1  0 = MONT (a*b*R^-1 mod Q), 1 = PLAIN (a*b mod Q)
- in_a  in  LANES*DATA_WIDTH  operand a per lane, lane 0 in LSBs
- in_b  in  LANES*DATA_WIDTH  operand b per lane
- in_tag  in  TAG_WIDTH  sideband, returned unchanged with result
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts beat
- out_result  out  LANES*DATA_WIDTH  canonical result per lane
- out_tag  out  TAG_WIDTH  tag of this beat
- range_err  out  1  sticky: an accepted operand was >= Q

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, range_err=0, all stage valid bits 0. out_result and out_tag are 0 after reset. in_ready=1 in the cycle after reset deasserts.
- Datapath, per lane:
  - Stage pair 1: p = a*b (2*DATA_WIDTH bits), then t1 = REDC(p), so t1 = a*b*R^-1 mod Q in [0, Q-1].
  - Stage pair 2: q = t1*C with C = R2_MOD_Q when mode=PLAIN, C = R_MOD_Q when mode=MONT. Then t2 = REDC(q).
  - Result: MONT yields a*b*R^-1, PLAIN yields a*b, both with identical latency.
- REDC(x): m = (x mod R)*QINV mod R; u = (x + m*Q) >> DATA_WIDTH; if u >= Q then u - Q. Internal sum width is 2*DATA_WIDTH+1; no truncation before the shift.
- Latency: 4 cycles from the accepting edge (in_valid && in_ready) to out_valid, with no stalls. Throughput is one beat per cycle.
- Pipeline has 4 registered stages, each with a valid bit. Mode and tag travel with the data.
- Stall rule: advance = !out_valid || out_ready. When advance=0, every stage holds. in_ready = advance (combinational).
- No bubble collapse; beats are never reordered, dropped or duplicated.
- A beat transfers out on a cycle with out_valid && out_ready.
- out_result and out_tag are held stable while out_valid && !out_ready.
- in_valid=0 inserts a bubble; stage valid bits propagate.
- range_err is set when a beat is accepted with any lane a or b >= Q. It stays set until rst. That beat's result is unspecified but its tag and position in the stream are preserved.
- Reset mid-operation: all in-flight beats are discarded; out_valid=0 the cycle after the rst edge.
- Simultaneous accept and emit under out_ready=1 is permitted every cycle.

Decomposition:
- ntt_pkg holds:
  - derived constants R_MOD_Q, R2_MOD_Q, QINV (= -Q^-1 mod R), computed by constant functions from Q and DATA_WIDTH
  - typedef mul_mode_e {MUL_MONT, MUL_PLAIN}
  - MUL_STAGE_CNT = 4
- Sub-module mont_redc: two-stage pipelined REDC with enable, one instance per lane per pair (2*LANES total).

Test Plan (Q=3329, DATA_WIDTH=12, R=4096, R_MOD_Q=767, R2_MOD_Q=2385):
- PLAIN, lane0 a=2 b=3, lane1 a=3328 b=3328, out_ready=1 -> 4 cycles later out_valid=1, results {6, 1}, tag echoed.
- MONT, a=767 b=5, lane1 a=0 b=1234 -> results {5, 0}.
- Back-to-back 8 beats alternating modes with random operands < Q -> 8 consecutive out_valid cycles, in order, each matching the golden model (PLAIN a*b%Q; MONT (a*b*R^-1)%Q).
- 6 beats issued, out_ready held 0 for 3 cycles after first out_valid -> in_ready drops when pipeline full, out_result stable, all 6 delivered in order, none lost.
- Beat with a=3329 -> range_err=1 and stays 1 across later valid beats; next valid beat still correct.
- rst pulsed while 3 beats in flight -> out_valid=0 next cycle, range_err=0, no stale beat ever emitted; a new beat after reset has latency 4.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and helpers for the NTT modular-multiply datapath.
package ntt_pkg;

  localparam int MUL_STAGE_CNT = 4;

  typedef enum logic {
    MUL_MONT  = 1'b0,
    MUL_PLAIN = 1'b1
  } mul_mode_e;

  // R mod Q with R = 2^w
  function automatic longint f_r_mod_q(longint q, int w);
    return (longint'(1) << w) % q;
  endfunction

  // R^2 mod Q, the factor that turns a Montgomery product back into a*b
  function automatic longint f_r2_mod_q(longint q, int w);
    longint r;
    r = f_r_mod_q(q, w);
    return (r * r) % q;
  endfunction

  // -Q^-1 mod R by Newton iteration; inv = q is already exact mod 8 for odd q
  function automatic longint f_qinv(longint q, int w);
    longint mask;
    longint inv;
    mask = (longint'(1) << w) - 1;
    inv  = q;
    for (int i = 0; i < 6; i++) inv = (inv * (2 - q * inv)) & mask;
    return (-inv) & mask;
  endfunction

  // Defaults for the Kyber field
  localparam int     DEF_Q    = 3329;
  localparam int     DEF_DW   = 12;
  localparam longint R_MOD_Q  = f_r_mod_q(DEF_Q, DEF_DW);
  localparam longint R2_MOD_Q = f_r2_mod_q(DEF_Q, DEF_DW);
  localparam longint QINV     = f_qinv(DEF_Q, DEF_DW);

endpackage

// File: rtl/mod_mul_pipe_if.sv
// Handshake bundle between a requester and the modular multiplier.
interface mod_mul_pipe_if #(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 12,
  parameter int TAG_WIDTH  = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_mode;
  logic [LANES*DATA_WIDTH-1:0] in_a;
  logic [LANES*DATA_WIDTH-1:0] in_b;
  logic [TAG_WIDTH-1:0]        in_tag;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_result;
  logic [TAG_WIDTH-1:0]        out_tag;
  logic                        range_err;

  modport master (
    output in_valid, in_mode, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, range_err
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, range_err
  );
endinterface

// File: rtl/mont_redc.sv
// Two-stage Montgomery reduction: y = x * R^-1 mod Q, canonical.
// Stage A latches x and m = (x mod R) * QINV mod R; stage B adds m*Q,
// shifts by W and does the single conditional subtract.
module mont_redc #(
  parameter int W    = 12,
  parameter int Q    = 3329,
  parameter int QINV = 3327
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [2*W-1:0] x,
  output logic [W-1:0]   y
);
  localparam logic [2*W-1:0] QINV_X = (2*W)'(QINV);
  localparam logic [2*W:0]   Q_S    = (2*W+1)'(Q);
  localparam logic [W:0]     Q_U    = (W+1)'(Q);

  logic [2*W-1:0] m_full;
  logic [W-1:0]   m_d, m_q;
  logic [2*W-1:0] x_q;
  logic [2*W:0]   sum;
  logic [W:0]     u, u_sub;

  assign m_full = (2*W)'(x[W-1:0]) * QINV_X;
  assign m_d    = W'(m_full);

  // stage A: hold x and its Montgomery quotient
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      m_q <= '0;
    end else if (en) begin
      x_q <= x;
      m_q <= m_d;
    end
  end

  // full-width sum so the carry into bit 2W survives the shift
  assign sum   = (2*W+1)'(x_q) + (2*W+1)'(m_q) * Q_S;
  assign u     = (W+1)'(sum >> W);
  assign u_sub = u - Q_U;

  // stage B: u < 2Q, one subtract makes it canonical
  always_ff @(posedge clk) begin
    if (rst)     y <= '0;
    else if (en) y <= (u >= Q_U) ? W'(u_sub) : W'(u);
  end
endmodule

// File: rtl/mod_mul_pipe.sv
// Multi-lane modular multiplier, 4-stage pipeline with valid/ready.
// Pair 1 reduces a*b to a*b*R^-1; pair 2 multiplies by R mod Q (MONT)
// or R^2 mod Q (PLAIN) and reduces again, so both modes share latency.
module mod_mul_pipe
  import ntt_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 12,
  parameter int Q          = DEF_Q,
  parameter int TAG_WIDTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  mod_mul_pipe_if.slave  bus
);
  localparam int          STAGES = MUL_STAGE_CNT;
  localparam int          W      = DATA_WIDTH;
  localparam int          K_QINV = int'(f_qinv(Q, W));
  localparam logic [W-1:0] K_R   = W'(f_r_mod_q(Q, W));
  localparam logic [W-1:0] K_R2  = W'(f_r2_mod_q(Q, W));
  localparam logic [W-1:0] Q_W   = W'(Q);

  logic                              advance;
  logic [LANES-1:0][W-1:0]           a_l, b_l, t1, t2;
  logic [LANES-1:0]                  oor;
  logic [STAGES:1]                   vld_q;
  logic [STAGES:0]                   vld_pipe;
  logic [STAGES:1][TAG_WIDTH-1:0]    tag_q;
  mul_mode_e                         mode_q1, mode_q2;
  logic                              range_err_q;

  assign a_l      = bus.in_a;
  assign b_l      = bus.in_b;
  assign vld_pipe = {vld_q, bus.in_valid};

  // whole pipe moves together; only a blocked output beat stalls it
  assign advance      = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready = advance;

  // valid bits, tag and mode ride alongside the lane data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      tag_q   <= '0;
      mode_q1 <= MUL_MONT;
      mode_q2 <= MUL_MONT;
    end else if (advance) begin
      vld_q   <= vld_pipe[STAGES-1:0];
      tag_q   <= {tag_q[STAGES-1:1], bus.in_tag};
      mode_q1 <= mul_mode_e'(bus.in_mode);
      mode_q2 <= mode_q1;
    end
  end

  // sticky flag for any accepted operand outside [0, Q-1]
  always_ff @(posedge clk) begin
    if (rst)                                      range_err_q <= 1'b0;
    else if (bus.in_valid && advance && (|oor))   range_err_q <= 1'b1;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2*W-1:0] p, q;
    logic [W-1:0]   c;

    assign oor[l] = (a_l[l] >= Q_W) || (b_l[l] >= Q_W);
    assign p      = (2*W)'(a_l[l]) * (2*W)'(b_l[l]);
    // mode_q2 is aligned with t1, which leaves the first reducer at stage 2
    assign c      = (mode_q2 == MUL_PLAIN) ? K_R2 : K_R;
    assign q      = (2*W)'(t1[l]) * (2*W)'(c);

    mont_redc #(.W(W), .Q(Q), .QINV(K_QINV)) u_redc1 (
      .clk (clk), .rst (rst), .en (advance), .x (p), .y (t1[l])
    );

    mont_redc #(.W(W), .Q(Q), .QINV(K_QINV)) u_redc2 (
      .clk (clk), .rst (rst), .en (advance), .x (q), .y (t2[l])
    );
  end

  assign bus.out_valid  = vld_pipe[STAGES];
  assign bus.out_result = t2;
  assign bus.out_tag    = tag_q[STAGES];
  assign bus.range_err  = range_err_q;
endmodule
